// File: rtl/xgmii_rs_fault_pkg.sv
// Shared encodings and XGMII byte/word constants for the reconciliation-sublayer
// link fault block.
package xgmii_rs_fault_pkg;

    typedef enum logic [1:0] {
        LF_OK     = 2'b00,
        LF_LOCAL  = 2'b01,
        LF_REMOTE = 2'b10
    } link_fault_e;

    localparam logic [7:0] SEQ_BYTE    = 8'h9C;
    localparam logic [7:0] LOCAL_BYTE  = 8'h01;
    localparam logic [7:0] REMOTE_BYTE = 8'h02;
    localparam logic [7:0] IDLE_BYTE   = 8'h07;

    localparam logic [63:0] IDLE_WORD = {8{IDLE_BYTE}};
    localparam logic [7:0]  IDLE_CTRL = 8'hFF;

    // A detected local fault is answered by signalling remote fault to the peer.
    localparam logic [63:0] RF_SEQ_WORD = {2{REMOTE_BYTE, 8'h00, 8'h00, SEQ_BYTE}};
    localparam logic [7:0]  RF_SEQ_CTRL = 8'h11;

endpackage

// File: rtl/xgmii_rs_fault_seq_detect.sv
// Classifies one 32-bit XGMII column as a local/remote fault sequence ordered set
// or as a non-sequence column.
module xgmii_seq_detect
    import xgmii_rs_fault_pkg::*;
(
    input  logic [31:0] col_data,
    input  logic [3:0]  col_ctrl,
    output logic        seq_valid,
    output link_fault_e seq_type
);

    logic seq_frame;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        seq_valid = 1'b0;
        seq_type  = LF_LOCAL;
        seq_frame = (col_ctrl == 4'b0001) && (col_data[7:0] == SEQ_BYTE) &&
                    (col_data[15:8] == 8'h00) && (col_data[23:16] == 8'h00);
        if (seq_frame && col_data[31:24] == LOCAL_BYTE) begin
            seq_valid = 1'b1;
            seq_type  = LF_LOCAL;
        end else if (seq_frame && col_data[31:24] == REMOTE_BYTE) begin
            seq_valid = 1'b1;
            seq_type  = LF_REMOTE;
        end
    end

endmodule

// File: rtl/xgmii_rs_fault.sv
// XGMII reconciliation-sublayer link fault detection with fault-driven transmit override.
// Two columns per cycle are folded through the fault counters, lower column first.
module xgmii_rs_fault
    import xgmii_rs_fault_pkg::*;
#(
    parameter int COL_CNT_MAX    = 128,
    parameter int SEQ_CNT_THRESH = 4
) (
    input  logic        clk156,
    input  logic        rst_n,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic [63:0] mac_txd,
    input  logic [7:0]  mac_txc,
    input  logic        override_en,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic [1:0]  link_fault,
    output logic        fault_change
);

    localparam int CW = $clog2(COL_CNT_MAX + 1);
    localparam int SW = $clog2(SEQ_CNT_THRESH + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COL_CNT_MAX);
    localparam logic [SW-1:0] SEQ_MAX = SW'(SEQ_CNT_THRESH);

    typedef struct packed {
        link_fault_e   fault;
        link_fault_e   seq_type;
        logic [SW-1:0] seq_cnt;
        logic [CW-1:0] col_cnt;
    } rs_state_t;

    function automatic rs_state_t step(rs_state_t s, logic valid, link_fault_e typ);
        rs_state_t n;
        n = s;
        if (valid) begin
            n.col_cnt = '0;
            if (typ == s.seq_type) begin
                if (s.seq_cnt != SEQ_MAX) n.seq_cnt = s.seq_cnt + 1'b1;
            end else begin
                n.seq_type = typ;
                n.seq_cnt  = SW'(1);
            end
        end else if (s.col_cnt != COL_MAX) begin
            n.col_cnt = s.col_cnt + 1'b1;
        end
        if (n.col_cnt == COL_MAX) begin
            n.seq_cnt = '0;
            n.fault   = LF_OK;
        end else if (n.seq_cnt == SEQ_MAX) begin
            n.fault = n.seq_type;
        end
        return n;
    endfunction

    logic        lo_valid, hi_valid;
    link_fault_e lo_type, hi_type;
    rs_state_t   state_q, state_d, state_mid;
    logic        fault_change_q, fault_change_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;

    xgmii_seq_detect u_det_lo (
        .col_data  (xgmii_rxd[31:0]),
        .col_ctrl  (xgmii_rxc[3:0]),
        .seq_valid (lo_valid),
        .seq_type  (lo_type)
    );

    xgmii_seq_detect u_det_hi (
        .col_data  (xgmii_rxd[63:32]),
        .col_ctrl  (xgmii_rxc[7:4]),
        .seq_valid (hi_valid),
        .seq_type  (hi_type)
    );

    always_comb begin
        state_mid      = step(state_q, lo_valid, lo_type);
        state_d        = step(state_mid, hi_valid, hi_type);
        fault_change_d = (state_d.fault != state_q.fault);
        txd_d          = mac_txd;
        txc_d          = mac_txc;
        // Override keys off the already-registered fault so switching lands on a cycle boundary.
        if (override_en && state_q.fault == LF_LOCAL) begin
            txd_d = RF_SEQ_WORD;
            txc_d = RF_SEQ_CTRL;
        end else if (override_en && state_q.fault == LF_REMOTE) begin
            txd_d = IDLE_WORD;
            txc_d = IDLE_CTRL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk156) begin
        if (!rst_n) begin
            state_q.fault    <= LF_OK;
            state_q.seq_type <= LF_LOCAL;
            state_q.seq_cnt  <= '0;
            state_q.col_cnt  <= '0;
            fault_change_q   <= 1'b0;
            txd_q            <= IDLE_WORD;
            txc_q            <= IDLE_CTRL;
        end else begin
            state_q        <= state_d;
            fault_change_q <= fault_change_d;
            txd_q          <= txd_d;
            txc_q          <= txc_d;
        end
    end

    assign link_fault   = state_q.fault;
    assign fault_change = fault_change_q;
    assign xgmii_txd    = txd_q;
    assign xgmii_txc    = txc_q;

endmodule

// File: tb/tb_xgmii_rs_fault.sv
// Scoreboard bench for xgmii_rs_fault: stimulus queues hand-derived expectations,
// a monitor compares them against the registered outputs each cycle.
module tb_xgmii_rs_fault;

    logic        clk156 = 1'b0;
    logic        rst_n  = 1'b0;
    logic [63:0] xgmii_rxd = '0;
    logic [7:0]  xgmii_rxc = '0;
    logic [63:0] mac_txd = '0;
    logic [7:0]  mac_txc = '0;
    logic        override_en = 1'b0;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [1:0]  link_fault;
    logic        fault_change;

    xgmii_rs_fault dut (
        .clk156       (clk156),
        .rst_n        (rst_n),
        .xgmii_rxd    (xgmii_rxd),
        .xgmii_rxc    (xgmii_rxc),
        .mac_txd      (mac_txd),
        .mac_txc      (mac_txc),
        .override_en  (override_en),
        .xgmii_txd    (xgmii_txd),
        .xgmii_txc    (xgmii_txc),
        .link_fault   (link_fault),
        .fault_change (fault_change)
    );

    always #5 clk156 = ~clk156;

    localparam logic [31:0] L_COL  = 32'h0100009C;
    localparam logic [31:0] R_COL  = 32'h0200009C;
    localparam logic [31:0] B_COL  = 32'h0300009C;
    localparam logic [31:0] I_COL  = 32'h07070707;
    localparam logic [3:0]  S_CTL  = 4'h1;
    localparam logic [3:0]  I_CTL  = 4'hF;
    localparam logic [63:0] RF_TXD = 64'h0200009C_0200009C;
    localparam logic [7:0]  RF_TXC = 8'h11;
    localparam logic [63:0] ID_TXD = 64'h07070707_07070707;
    localparam logic [7:0]  ID_TXC = 8'hFF;

    typedef struct {
        string       name;
        logic [1:0]  lf;
        logic        fc;
        logic [63:0] txd;
        logic [7:0]  txc;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] prev_lf = 2'b00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk156);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, " link_fault"},   64'(link_fault),   64'(e.lf));
                check({e.name, " fault_change"}, 64'(fault_change), 64'(e.fc));
                check({e.name, " xgmii_txd"},    xgmii_txd,         e.txd);
                check({e.name, " xgmii_txc"},    64'(xgmii_txc),    64'(e.txc));
            end
        end
    end

    task automatic cyc(input string name, input logic [31:0] lo, input logic [3:0] loc,
                       input logic [31:0] hi, input logic [3:0] hic,
                       input logic ovr, input logic [1:0] exp_lf);
        exp_t e;
        @(negedge clk156);
        rst_n       = 1'b1;
        xgmii_rxd   = {hi, lo};
        xgmii_rxc   = {hic, loc};
        mac_txd     = {$urandom(), $urandom()};
        mac_txc     = 8'($urandom());
        override_en = ovr;
        e.name = name;
        e.lf   = exp_lf;
        e.fc   = (exp_lf != prev_lf);
        if (ovr && prev_lf == 2'b01) begin
            e.txd = RF_TXD;
            e.txc = RF_TXC;
        end else if (ovr && prev_lf == 2'b10) begin
            e.txd = ID_TXD;
            e.txc = ID_TXC;
        end else begin
            e.txd = mac_txd;
            e.txc = mac_txc;
        end
        sb.push_back(e);
        prev_lf = exp_lf;
    endtask

    task automatic rst_cyc(input string name);
        exp_t e;
        @(negedge clk156);
        rst_n     = 1'b0;
        mac_txd   = {$urandom(), $urandom()};
        mac_txc   = 8'($urandom());
        e.name = name;
        e.lf   = 2'b00;
        e.fc   = 1'b0;
        e.txd  = ID_TXD;
        e.txc  = ID_TXC;
        sb.push_back(e);
        prev_lf = 2'b00;
    endtask

    initial begin : stimulus
        rst_cyc("reset0");
        rst_cyc("reset1");

        // Local sequence in the lower column only: fault on the 4th cycle.
        for (int i = 0; i < 4; i++) cyc("lf_lower", L_COL, S_CTL, I_COL, I_CTL, 1'b0, (i == 3) ? 2'b01 : 2'b00);
        repeat (2) cyc("lf_hold", I_COL, I_CTL, I_COL, I_CTL, 1'b0, 2'b01);
        rst_cyc("reset2");

        // Remote sequences in both columns: fault after 2 cycles, idle override follows.
        cyc("rf_both", R_COL, S_CTL, R_COL, S_CTL, 1'b1, 2'b00);
        cyc("rf_both", R_COL, S_CTL, R_COL, S_CTL, 1'b1, 2'b10);
        repeat (2) cyc("rf_tx", I_COL, I_CTL, I_COL, I_CTL, 1'b1, 2'b10);
        rst_cyc("reset3");

        // Local fault, then exactly 128 non-sequence columns clear it.
        cyc("lf_both", L_COL, S_CTL, L_COL, S_CTL, 1'b1, 2'b00);
        cyc("lf_both", L_COL, S_CTL, L_COL, S_CTL, 1'b1, 2'b01);
        for (int i = 1; i <= 64; i++) cyc("col_clear", I_COL, I_CTL, I_COL, I_CTL, 1'b1, (i == 64) ? 2'b00 : 2'b01);
        repeat (2) cyc("passthru", I_COL, I_CTL, I_COL, I_CTL, 1'b1, 2'b00);

        // Alternating types never accumulate.
        for (int i = 0; i < 20; i++) cyc("alternate", (i % 2 == 1) ? R_COL : L_COL, S_CTL, I_COL, I_CTL, 1'b0, 2'b00);

        // Malformed sequences: lane 3 = 0x03, and a control bit set on lane 1.
        for (int i = 0; i < 10; i++) cyc("lane3_03", B_COL, S_CTL, B_COL, S_CTL, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) cyc("bad_ctrl", L_COL, 4'h3, L_COL, 4'h3, 1'b0, 2'b00);

        // Local fault with override, then reset mid-fault.
        cyc("lf_ovr", L_COL, S_CTL, L_COL, S_CTL, 1'b1, 2'b00);
        cyc("lf_ovr", L_COL, S_CTL, L_COL, S_CTL, 1'b1, 2'b01);
        cyc("lf_ovr_tx", I_COL, I_CTL, I_COL, I_CTL, 1'b1, 2'b01);
        rst_cyc("rst_mid_fault");
        cyc("post_rst", I_COL, I_CTL, I_COL, I_CTL, 1'b1, 2'b00);

        // Sequence count survives sparse non-sequence columns; upper column only.
        for (int i = 0; i < 3; i++) cyc("partial", I_COL, I_CTL, L_COL, S_CTL, 1'b0, 2'b00);
        repeat (5) cyc("partial_gap", I_COL, I_CTL, I_COL, I_CTL, 1'b0, 2'b00);
        cyc("partial_done", I_COL, I_CTL, L_COL, S_CTL, 1'b0, 2'b01);

        // Type changes hold the fault; remote then takes over directly.
        cyc("type_flip", R_COL, S_CTL, L_COL, S_CTL, 1'b0, 2'b01);
        cyc("lf_to_rf", R_COL, S_CTL, R_COL, S_CTL, 1'b0, 2'b01);
        cyc("lf_to_rf", R_COL, S_CTL, R_COL, S_CTL, 1'b0, 2'b10);
        cyc("rf_sat", R_COL, S_CTL, R_COL, S_CTL, 1'b1, 2'b10);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk156);
        check("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
